// File: rtl/tlul_sram_ctrl_pkg.sv
// Shared types and constants for the TL-UL SRAM device controller.
package tlul_sram_ctrl_pkg;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

    typedef struct packed {
        mubi4_t instr_type;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic       is_read;
        logic       error;
        logic [7:0] source;
        logic [1:0] size;
    } rsp_meta_t;

    typedef enum logic [2:0] {
        ErrNone, ErrOpcode, ErrSize, ErrAlign, ErrRange, ErrMask, ErrFetch
    } err_cause_e;

    // Byte lanes touched by an access of 2**size bytes at the given word offset.
    function automatic logic [3:0] size_mask(logic [1:0] size, logic [1:0] offset);
        logic [3:0] lanes;
        unique case (size)
            2'd0:    lanes = 4'b0001 << offset;
            2'd1:    lanes = 4'b0011 << offset;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/tlul_sram_ctrl_if.sv
// TL-UL A/D channel bundle between host and the SRAM controller.
interface tlul_sram_ctrl_if;
    import tlul_sram_ctrl_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport slave  (input h2d, output d2h);
    modport master (output h2d, input d2h);
endinterface

// File: rtl/tlul_sram_ctrl_rspq.sv
// In-order response queue; read data lands in the newest slot one cycle after push.
module tlul_sram_ctrl_rspq import tlul_sram_ctrl_pkg::*; #(
    parameter int unsigned Outstanding = 2,
    localparam int unsigned IdxW = (Outstanding > 1) ? $clog2(Outstanding) : 1,
    localparam int unsigned CntW = $clog2(Outstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  rsp_meta_t       push_meta,
    input  logic            late_we,
    input  logic [31:0]     late_data,
    input  logic            pop,
    output rsp_meta_t       head_meta,
    output logic [31:0]     head_data,
    output logic [CntW-1:0] count
);

    rsp_meta_t       meta_q [Outstanding];
    logic [31:0]     data_q [Outstanding];
    logic [IdxW-1:0] wptr_q, rptr_q, last_q;
    logic [CntW-1:0] count_q;

    function automatic logic [IdxW-1:0] inc(logic [IdxW-1:0] p);
        return (p == IdxW'(Outstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slot storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Outstanding; i++) begin
                meta_q[i] <= '0;
                data_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                meta_q[wptr_q] <= push_meta;
                // Writes and errors keep this; good reads overwrite it next cycle.
                data_q[wptr_q] <= ErrData;
                wptr_q         <= inc(wptr_q);
                last_q         <= wptr_q;
            end
            if (late_we) begin
                data_q[last_q] <= late_data;
            end
            if (pop) begin
                rptr_q <= inc(rptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Head view; forward RAM data when the head is the read still being filled.
    always_comb begin
        head_meta = meta_q[rptr_q];
        head_data = (late_we && (last_q == rptr_q)) ? late_data : data_q[rptr_q];
        count     = count_q;
    end

endmodule

// File: rtl/tlul_sram_ctrl.sv
// TL-UL device front end for a 1-cycle-latency single-port SRAM.
module tlul_sram_ctrl import tlul_sram_ctrl_pkg::*; #(
    parameter int unsigned Depth       = 2048,
    parameter int unsigned Outstanding = 2,
    parameter bit          EnIfetch    = 1'b1,
    localparam int unsigned Aw         = $clog2(Depth),
    localparam int unsigned CntW       = $clog2(Outstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tlul_sram_ctrl_if.slave      tl,
    input  mubi4_t               en_ifetch_i,
    output logic                 req_o,
    output logic                 we_o,
    output logic [Aw-1:0]        addr_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          wmask_o,
    input  logic [31:0]          rdata_i
);

    err_cause_e      err_cause;
    logic            a_ready, a_hs, is_get, pop, rd_pending_q;
    logic [3:0]      need_mask;
    logic [CntW-1:0] count;
    rsp_meta_t       push_meta, head_meta;
    logic [31:0]     head_data;
    logic            unused_param;

    assign unused_param = ^tl.h2d.a_param;

    // Request classification; the first failing check names the cause.
    always_comb begin
        err_cause = ErrNone;
        need_mask = size_mask(tl.h2d.a_size, tl.h2d.a_address[1:0]);
        if (!(tl.h2d.a_opcode inside {OpGet, OpPutFull, OpPutPartial})) begin
            err_cause = ErrOpcode;
        end else if (tl.h2d.a_size == 2'd3) begin
            err_cause = ErrSize;
        end else if ((tl.h2d.a_size == 2'd1 && tl.h2d.a_address[0]) ||
                     (tl.h2d.a_size == 2'd2 && tl.h2d.a_address[1:0] != 2'd0)) begin
            err_cause = ErrAlign;
        end else if (tl.h2d.a_address[31:2] >= 30'(Depth)) begin
            err_cause = ErrRange;
        end else if (tl.h2d.a_opcode == OpPutFull &&
                     (tl.h2d.a_mask & need_mask) != need_mask) begin
            err_cause = ErrMask;
        end else if (tl.h2d.a_opcode == OpGet && tl.h2d.a_user.instr_type == MuBi4True &&
                     (!EnIfetch || en_ifetch_i != MuBi4True)) begin
            err_cause = ErrFetch;
        end
    end

    // RAM strobe and write controls; errored requests never reach the RAM.
    always_comb begin
        a_ready = (count < CntW'(Outstanding));
        a_hs    = tl.h2d.a_valid && a_ready;
        is_get  = (tl.h2d.a_opcode == OpGet);
        req_o   = a_hs && (err_cause == ErrNone);
        we_o    = req_o && !is_get;
        addr_o  = tl.h2d.a_address[Aw+1:2];
        wdata_o = tl.h2d.a_data;
        wmask_o = '0;
        for (int i = 0; i < 4; i++) begin
            wmask_o[8*i +: 8] = {8{tl.h2d.a_mask[i]}};
        end
        push_meta = '{is_read: is_get, error: (err_cause != ErrNone),
                      source: tl.h2d.a_source, size: tl.h2d.a_size};
    end

    // Marks that rdata_i carries data for the newest queue entry this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= req_o && is_get;
        end
    end

    tlul_sram_ctrl_rspq #(
        .Outstanding (Outstanding)
    ) u_rspq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (a_hs),
        .push_meta (push_meta),
        .late_we   (rd_pending_q),
        .late_data (rdata_i),
        .pop       (pop),
        .head_meta (head_meta),
        .head_data (head_data),
        .count     (count)
    );

    // D channel driven straight from the queue head.
    always_comb begin
        tl.d2h          = '0;
        tl.d2h.a_ready  = a_ready;
        tl.d2h.d_valid  = (count != '0);
        tl.d2h.d_opcode = head_meta.is_read ? OpAccessAckData : OpAccessAck;
        tl.d2h.d_size   = head_meta.size;
        tl.d2h.d_source = head_meta.source;
        tl.d2h.d_error  = head_meta.error;
        tl.d2h.d_data   = head_data;
        pop             = (count != '0) && tl.h2d.d_ready;
    end

endmodule
